// File: rtl/alu_operand_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_stage_pkg
// Description : Shared widths, ALU control codes, the ID/EX field bundle and
//               the immediate-extension helper for the ALU operand stage.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_operand_stage_pkg;

    localparam int PKG_DATA_W  = 32;
    localparam int PKG_REG_AW  = 5;
    localparam int PKG_CTRL_W  = 4;
    localparam int PKG_IMM_W   = 16;
    localparam int PKG_SHAMT_W = 5;

    // ALU control encodings understood by the downstream ALU
    localparam logic [PKG_CTRL_W-1:0] ALU_AND = 4'd0;
    localparam logic [PKG_CTRL_W-1:0] ALU_OR  = 4'd1;
    localparam logic [PKG_CTRL_W-1:0] ALU_ADD = 4'd2;
    localparam logic [PKG_CTRL_W-1:0] ALU_SUB = 4'd6;
    localparam logic [PKG_CTRL_W-1:0] ALU_SLT = 4'd7;
    localparam logic [PKG_CTRL_W-1:0] ALU_SRA = 4'd8;
    localparam logic [PKG_CTRL_W-1:0] ALU_LUI = 4'd9;
    localparam logic [PKG_CTRL_W-1:0] ALU_NOR = 4'd12;

    // Everything the ID/EX register carries for one instruction slot.
    // An all-zero bundle is a bubble.
    typedef struct packed {
        logic                   valid;
        logic [PKG_REG_AW-1:0]  rs_addr;
        logic [PKG_REG_AW-1:0]  rt_addr;
        logic [PKG_DATA_W-1:0]  rs_data;
        logic [PKG_DATA_W-1:0]  rt_data;
        logic [PKG_IMM_W-1:0]   imm;
        logic [PKG_SHAMT_W-1:0] shamt;
        logic [PKG_CTRL_W-1:0]  alu_ctrl;
        logic                   alu_src;
        logic                   shift_src;
        logic                   sign_ext;
        logic [PKG_REG_AW-1:0]  rd;
        logic                   reg_write;
        logic                   mem_read;
    } id_ex_t;

    // Widen the 16-bit instruction immediate to a full operand.
    function automatic logic [PKG_DATA_W-1:0] extend_imm(
        input logic [PKG_IMM_W-1:0] imm,
        input logic                 sign_ext
    );
        logic fill;
        fill = sign_ext & imm[PKG_IMM_W-1];
        return {{(PKG_DATA_W-PKG_IMM_W){fill}}, imm};
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_operand_stage_fwd_select.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_stage_fwd_select
// Description : Forwarding priority mux for one source operand. The younger
//               EX/MEM result beats MEM/WB; register 0 is never forwarded.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_stage_fwd_select
    import alu_operand_stage_pkg::*;
#(
    parameter int DATA_W = PKG_DATA_W,
    parameter int REG_AW = PKG_REG_AW
) (
    input  logic [REG_AW-1:0] addr,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_data,
    output logic [DATA_W-1:0] fwd_data
);

    logic w_hit_exmem;
    logic w_hit_memwb;

    assign w_hit_exmem = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == addr);
    assign w_hit_memwb = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == addr);

    // Pick the most recent producer of this register, else the file value
    always_comb begin
        fwd_data = reg_data;
        if (w_hit_exmem) begin
            fwd_data = exmem_result;
        end else if (w_hit_memwb) begin
            fwd_data = memwb_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_stage
// Description : ID/EX pipeline register feeding the ALU. Applies EX/MEM and
//               MEM/WB forwarding, selects register/immediate/shamt operands,
//               detects load-use hazards and handles stall and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int DATA_W = PKG_DATA_W,
    parameter int REG_AW = PKG_REG_AW,
    parameter int CTRL_W = PKG_CTRL_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_addr_i,
    input  logic [REG_AW-1:0] id_rt_addr_i,
    input  logic [DATA_W-1:0] id_rs_data_i,
    input  logic [DATA_W-1:0] id_rt_data_i,
    input  logic [15:0]       id_imm_i,
    input  logic [4:0]        id_shamt_i,
    input  logic [CTRL_W-1:0] id_alu_ctrl_i,
    input  logic              id_alu_src_i,
    input  logic              id_shift_src_i,
    input  logic              id_sign_ext_i,
    input  logic [REG_AW-1:0] id_rd_addr_i,
    input  logic              id_reg_write_i,
    input  logic              id_mem_read_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              exmem_reg_write_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic [DATA_W-1:0] exmem_result_i,
    input  logic              memwb_reg_write_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    input  logic [DATA_W-1:0] memwb_data_i,
    output logic [DATA_W-1:0] src1_o,
    output logic [DATA_W-1:0] src2_o,
    output logic [CTRL_W-1:0] alu_ctrl_o,
    output logic [DATA_W-1:0] ex_rt_data_o,
    output logic              ex_valid_o,
    output logic              ex_reg_write_o,
    output logic              ex_mem_read_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic              load_use_stall_o
);

    id_ex_t            r_stage;
    id_ex_t            w_capture;
    logic              w_load_use;
    logic [DATA_W-1:0] w_fwd_rs;
    logic [DATA_W-1:0] w_fwd_rt;
    logic [DATA_W-1:0] w_src1_sel;
    logic [DATA_W-1:0] w_src2_sel;

    // Bundle the decoded ID fields into the form held by the stage register
    always_comb begin
        w_capture           = '0;
        w_capture.valid     = id_valid_i;
        w_capture.rs_addr   = id_rs_addr_i;
        w_capture.rt_addr   = id_rt_addr_i;
        w_capture.rs_data   = id_rs_data_i;
        w_capture.rt_data   = id_rt_data_i;
        w_capture.imm       = id_imm_i;
        w_capture.shamt     = id_shamt_i;
        w_capture.alu_ctrl  = id_alu_ctrl_i;
        w_capture.alu_src   = id_alu_src_i;
        w_capture.shift_src = id_shift_src_i;
        w_capture.sign_ext  = id_sign_ext_i;
        w_capture.rd        = id_rd_addr_i;
        w_capture.reg_write = id_reg_write_i;
        w_capture.mem_read  = id_mem_read_i;
    end

    // A load in EX whose destination is read by the ID instruction cannot be
    // forwarded in time; a stall already freezes ID so no extra request then.
    assign w_load_use = r_stage.valid && r_stage.mem_read && (r_stage.rd != '0)
                        && id_valid_i && !stall_i
                        && ((id_rs_addr_i == r_stage.rd) || (id_rt_addr_i == r_stage.rd));

    assign load_use_stall_o = w_load_use;

    // Stage register: reset, then hold on stall, bubble on flush or hazard
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stage <= '0;
        end else if (stall_i) begin
            r_stage <= r_stage;
        end else if (flush_i || w_load_use) begin
            r_stage          <= '0;
            r_stage.alu_ctrl <= ALU_AND;
        end else begin
            r_stage <= w_capture;
        end
    end

    alu_operand_stage_fwd_select #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_fwd_rs (
        .addr            (r_stage.rs_addr),
        .reg_data        (r_stage.rs_data),
        .exmem_reg_write (exmem_reg_write_i),
        .exmem_rd        (exmem_rd_i),
        .exmem_result    (exmem_result_i),
        .memwb_reg_write (memwb_reg_write_i),
        .memwb_rd        (memwb_rd_i),
        .memwb_data      (memwb_data_i),
        .fwd_data        (w_fwd_rs)
    );

    alu_operand_stage_fwd_select #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_fwd_rt (
        .addr            (r_stage.rt_addr),
        .reg_data        (r_stage.rt_data),
        .exmem_reg_write (exmem_reg_write_i),
        .exmem_rd        (exmem_rd_i),
        .exmem_result    (exmem_result_i),
        .memwb_reg_write (memwb_reg_write_i),
        .memwb_rd        (memwb_rd_i),
        .memwb_data      (memwb_data_i),
        .fwd_data        (w_fwd_rt)
    );

    // Operand muxes: shift amount replaces rs, extended immediate replaces rt
    always_comb begin
        w_src1_sel = w_fwd_rs;
        w_src2_sel = w_fwd_rt;
        if (r_stage.shift_src) begin
            w_src1_sel = {{(DATA_W-PKG_SHAMT_W){1'b0}}, r_stage.shamt};
        end
        if (r_stage.alu_src) begin
            w_src2_sel = extend_imm(r_stage.imm, r_stage.sign_ext);
        end
    end

    // Data outputs are quiet for an empty slot so the ALU sees clean zeros
    always_comb begin
        src1_o       = '0;
        src2_o       = '0;
        ex_rt_data_o = '0;
        if (r_stage.valid) begin
            src1_o       = w_src1_sel;
            src2_o       = w_src2_sel;
            ex_rt_data_o = w_fwd_rt;
        end
    end

    assign alu_ctrl_o     = r_stage.alu_ctrl;
    assign ex_valid_o     = r_stage.valid;
    assign ex_reg_write_o = r_stage.reg_write;
    assign ex_mem_read_o  = r_stage.mem_read;
    assign ex_rd_o        = r_stage.rd;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_operand_stage
// Description : Self-checking bench for alu_operand_stage with a queue-based
//               scoreboard of expected EX-side outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        id_valid_i;
    logic [4:0]  id_rs_addr_i, id_rt_addr_i, id_rd_addr_i, id_shamt_i;
    logic [31:0] id_rs_data_i, id_rt_data_i;
    logic [15:0] id_imm_i;
    logic [3:0]  id_alu_ctrl_i;
    logic        id_alu_src_i, id_shift_src_i, id_sign_ext_i;
    logic        id_reg_write_i, id_mem_read_i;
    logic        stall_i, flush_i;
    logic        exmem_reg_write_i, memwb_reg_write_i;
    logic [4:0]  exmem_rd_i, memwb_rd_i;
    logic [31:0] exmem_result_i, memwb_data_i;
    logic [31:0] src1_o, src2_o, ex_rt_data_o;
    logic [3:0]  alu_ctrl_o;
    logic        ex_valid_o, ex_reg_write_o, ex_mem_read_o, load_use_stall_o;
    logic [4:0]  ex_rd_o;

    typedef struct packed {
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] rt;
        logic [3:0]  ctrl;
        logic        valid;
        logic        rw;
        logic        mr;
        logic [4:0]  rd;
    } out_t;

    out_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .id_valid_i        (id_valid_i),
        .id_rs_addr_i      (id_rs_addr_i),
        .id_rt_addr_i      (id_rt_addr_i),
        .id_rs_data_i      (id_rs_data_i),
        .id_rt_data_i      (id_rt_data_i),
        .id_imm_i          (id_imm_i),
        .id_shamt_i        (id_shamt_i),
        .id_alu_ctrl_i     (id_alu_ctrl_i),
        .id_alu_src_i      (id_alu_src_i),
        .id_shift_src_i    (id_shift_src_i),
        .id_sign_ext_i     (id_sign_ext_i),
        .id_rd_addr_i      (id_rd_addr_i),
        .id_reg_write_i    (id_reg_write_i),
        .id_mem_read_i     (id_mem_read_i),
        .stall_i           (stall_i),
        .flush_i           (flush_i),
        .exmem_reg_write_i (exmem_reg_write_i),
        .exmem_rd_i        (exmem_rd_i),
        .exmem_result_i    (exmem_result_i),
        .memwb_reg_write_i (memwb_reg_write_i),
        .memwb_rd_i        (memwb_rd_i),
        .memwb_data_i      (memwb_data_i),
        .src1_o            (src1_o),
        .src2_o            (src2_o),
        .alu_ctrl_o        (alu_ctrl_o),
        .ex_rt_data_o      (ex_rt_data_o),
        .ex_valid_o        (ex_valid_o),
        .ex_reg_write_o    (ex_reg_write_o),
        .ex_mem_read_o     (ex_mem_read_o),
        .ex_rd_o           (ex_rd_o),
        .load_use_stall_o  (load_use_stall_o)
    );

    function automatic out_t sample();
        out_t o;
        o.src1 = src1_o;  o.src2 = src2_o;  o.rt = ex_rt_data_o;
        o.ctrl = alu_ctrl_o; o.valid = ex_valid_o; o.rw = ex_reg_write_o;
        o.mr = ex_mem_read_o; o.rd = ex_rd_o;
        return o;
    endfunction

    function automatic out_t mk(input logic [31:0] s1, s2, rt, input logic [3:0] c,
                                input logic v, rw, mr, input logic [4:0] rd);
        out_t o;
        o.src1 = s1; o.src2 = s2; o.rt = rt; o.ctrl = c;
        o.valid = v; o.rw = rw; o.mr = mr; o.rd = rd;
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, rt,
                          input logic [31:0] rsd, rtd, input logic [15:0] imm,
                          input logic [4:0] sh, input logic [3:0] ctrl,
                          input logic asrc, ssrc, sext, input logic [4:0] rd,
                          input logic rw, mr);
        id_valid_i = v;   id_rs_addr_i = rs; id_rt_addr_i = rt;
        id_rs_data_i = rsd; id_rt_data_i = rtd; id_imm_i = imm;
        id_shamt_i = sh;  id_alu_ctrl_i = ctrl; id_alu_src_i = asrc;
        id_shift_src_i = ssrc; id_sign_ext_i = sext; id_rd_addr_i = rd;
        id_reg_write_i = rw; id_mem_read_i = mr;
    endtask

    task automatic set_fwd(input logic exw, input logic [4:0] exrd, input logic [31:0] exres,
                           input logic mww, input logic [4:0] mwrd, input logic [31:0] mwd);
        exmem_reg_write_i = exw; exmem_rd_i = exrd; exmem_result_i = exres;
        memwb_reg_write_i = mww; memwb_rd_i = mwrd; memwb_data_i = mwd;
    endtask

    task automatic test_reset();
        out_t e, g;
        rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        set_fwd(1, 5'd3, 32'hDEAD, 1, 5'd3, 32'hBEEF);
        set_id(1, 5'd3, 5'd3, 32'h1234, 32'h5678, 16'hABCD, 5'd7, 4'd2, 1, 1, 1, 5'd3, 1, 1);
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back('0);
            tick();
            e = sb_q.pop_front(); g = sample();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL reset_outputs cyc%0d got=%h exp=%h", i, g, e);
            end
            checks++;
            if (load_use_stall_o !== 1'b0) begin
                failures++;
                $display("FAIL reset_load_use got=%b exp=0", load_use_stall_o);
            end
        end
        rst_i = 1'b0;
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_add();
        out_t e, g;
        set_id(1, 5'd1, 5'd2, 32'd5, 32'd7, 16'h0, 5'd0, 4'd2, 0, 0, 1, 5'd3, 1, 0);
        sb_q.push_back(mk(32'd5, 32'd7, 32'd7, 4'd2, 1, 1, 0, 5'd3));
        tick();
        e = sb_q.pop_front(); g = sample();
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL add_basic got=%h exp=%h", g, e);
        end
    endtask

    task automatic test_forward();
        out_t e, g;
        set_id(1, 5'd1, 5'd2, 32'd0, 32'd9, 16'h0, 5'd0, 4'd2, 0, 0, 0, 5'd5, 1, 0);
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // both stages target rs: EX/MEM must win
        set_fwd(1, 5'd1, 32'h10, 1, 5'd1, 32'h20);
        sb_q.push_back(mk(32'h10, 32'd9, 32'd9, 4'd2, 1, 1, 0, 5'd5));
        #1;
        e = sb_q.pop_front(); g = sample();
        checks++;
        if (g !== e) begin failures++; $display("FAIL fwd_exmem_priority got=%h exp=%h", g, e); end
        set_fwd(0, 5'd1, 32'h10, 1, 5'd1, 32'h20);
        sb_q.push_back(mk(32'h20, 32'd9, 32'd9, 4'd2, 1, 1, 0, 5'd5));
        #1;
        e = sb_q.pop_front(); g = sample();
        checks++;
        if (g !== e) begin failures++; $display("FAIL fwd_memwb got=%h exp=%h", g, e); end
        // rt forwarding reaches both src2 and store data
        set_fwd(0, 5'd0, 32'h0, 1, 5'd2, 32'h77);
        sb_q.push_back(mk(32'h0, 32'h77, 32'h77, 4'd2, 1, 1, 0, 5'd5));
        #1;
        e = sb_q.pop_front(); g = sample();
        checks++;
        if (g !== e) begin failures++; $display("FAIL fwd_rt got=%h exp=%h", g, e); end
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 5'd0, 5'd0, 32'd0, 32'd0, 16'h0, 5'd0, 4'd2, 0, 0, 0, 5'd5, 1, 0);
        @(negedge clk);
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_fwd(1, 5'd0, 32'hFFFF, 1, 5'd0, 32'h20);
        sb_q.push_back(mk(32'h0, 32'h0, 32'h0, 4'd2, 1, 1, 0, 5'd5));
        #1;
        e = sb_q.pop_front(); g = sample();
        checks++;
        if (g !== e) begin failures++; $display("FAIL fwd_reg0 got=%h exp=%h", g, e); end
        set_fwd(0, 0, 0, 0, 0, 0);
        @(negedge clk);
    endtask

    task automatic test_load_use();
        out_t e, g;
        // lw r4 <- mem[r1 + 8]
        set_id(1, 5'd1, 5'd0, 32'd100, 32'd0, 16'd8, 5'd0, 4'd2, 1, 0, 1, 5'd4, 1, 1);
        tick();
        set_id(1, 5'd4, 5'd6, 32'h44, 32'h66, 16'h0, 5'd0, 4'd2, 0, 0, 0, 5'd7, 1, 0);
        #1;
        checks++;
        if (load_use_stall_o !== 1'b1) begin
            failures++; $display("FAIL load_use_detect got=%b exp=1", load_use_stall_o);
        end
        sb_q.push_back('0);
        tick();
        e = sb_q.pop_front(); g = sample();
        checks++;
        if (g !== e) begin failures++; $display("FAIL load_use_bubble got=%h exp=%h", g, e); end
        sb_q.push_back(mk(32'h44, 32'h66, 32'h66, 4'd2, 1, 1, 0, 5'd7));
        tick();
        e = sb_q.pop_front(); g = sample();
        checks++;
        if (g !== e) begin failures++; $display("FAIL load_use_resume got=%h exp=%h", g, e); end
        // same hazard while the stage is stalled
        set_id(1, 5'd1, 5'd0, 32'd100, 32'd0, 16'd8, 5'd0, 4'd2, 1, 0, 1, 5'd4, 1, 1);
        tick();
        set_id(1, 5'd6, 5'd4, 32'h44, 32'h66, 16'h0, 5'd0, 4'd2, 0, 0, 0, 5'd7, 1, 0);
        stall_i = 1'b1;
        #1;
        checks++;
        if (load_use_stall_o !== 1'b0) begin
            failures++; $display("FAIL load_use_masked_by_stall got=%b exp=0", load_use_stall_o);
        end
        sb_q.push_back(mk(32'd100, 32'd8, 32'd0, 4'd2, 1, 1, 1, 5'd4));
        tick();
        e = sb_q.pop_front(); g = sample();
        checks++;
        if (g !== e) begin failures++; $display("FAIL load_use_stall_hold got=%h exp=%h", g, e); end
        stall_i = 1'b0; flush_i = 1'b1;
        #1;
        checks++;
        if (load_use_stall_o !== 1'b1) begin
            failures++; $display("FAIL load_use_with_flush got=%b exp=1", load_use_stall_o);
        end
        sb_q.push_back('0);
        tick();
        e = sb_q.pop_front(); g = sample();
        checks++;
        if (g !== e) begin failures++; $display("FAIL load_use_flush_bubble got=%h exp=%h", g, e); end
        flush_i = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_back_to_back();
        out_t e, g;
        // sign-extended, zero-extended immediate, then shift-amount operand
        set_id(1, 5'd1, 5'd2, 32'h11, 32'h55, 16'hFFFC, 5'd0, 4'd2, 1, 0, 1, 5'd6, 1, 0);
        sb_q.push_back(mk(32'h11, 32'hFFFFFFFC, 32'h55, 4'd2, 1, 1, 0, 5'd6));
        tick();
        e = sb_q.pop_front(); g = sample();
        checks++;
        if (g !== e) begin failures++; $display("FAIL imm_sign_ext got=%h exp=%h", g, e); end
        set_id(1, 5'd1, 5'd2, 32'h11, 32'h55, 16'hFFFC, 5'd0, 4'd2, 1, 0, 0, 5'd6, 1, 0);
        sb_q.push_back(mk(32'h11, 32'h0000FFFC, 32'h55, 4'd2, 1, 1, 0, 5'd6));
        tick();
        e = sb_q.pop_front(); g = sample();
        checks++;
        if (g !== e) begin failures++; $display("FAIL imm_zero_ext got=%h exp=%h", g, e); end
        set_id(1, 5'd1, 5'd2, 32'h11, 32'h55, 16'h0, 5'd3, 4'd8, 0, 1, 0, 5'd6, 1, 0);
        sb_q.push_back(mk(32'd3, 32'h55, 32'h55, 4'd8, 1, 1, 0, 5'd6));
        tick();
        e = sb_q.pop_front(); g = sample();
        checks++;
        if (g !== e) begin failures++; $display("FAIL shift_shamt got=%h exp=%h", g, e); end
    endtask

    task automatic test_stall_flush();
        out_t e, g;
        set_id(1, 5'd3, 5'd5, 32'h30, 32'h50, 16'h0, 5'd0, 4'd1, 0, 0, 0, 5'd9, 1, 0);
        sb_q.push_back(mk(32'h30, 32'h50, 32'h50, 4'd1, 1, 1, 0, 5'd9));
        tick();
        e = sb_q.pop_front(); g = sample();
        checks++;
        if (g !== e) begin failures++; $display("FAIL sf_load got=%h exp=%h", g, e); end
        set_id(1, 5'd7, 5'd8, 32'h70, 32'h80, 16'h0, 5'd0, 4'd6, 0, 0, 0, 5'd10, 1, 0);
        stall_i = 1'b1; flush_i = 1'b1;
        sb_q.push_back(mk(32'h30, 32'h50, 32'h50, 4'd1, 1, 1, 0, 5'd9));
        tick();
        e = sb_q.pop_front(); g = sample();
        checks++;
        if (g !== e) begin failures++; $display("FAIL stall_over_flush got=%h exp=%h", g, e); end
        stall_i = 1'b0;
        sb_q.push_back('0);
        tick();
        e = sb_q.pop_front(); g = sample();
        checks++;
        if (g !== e) begin failures++; $display("FAIL flush_bubble got=%h exp=%h", g, e); end
        flush_i = 1'b0;
        // reset wins over a concurrent stall
        sb_q.push_back(mk(32'h70, 32'h80, 32'h80, 4'd6, 1, 1, 0, 5'd10));
        tick();
        e = sb_q.pop_front(); g = sample();
        checks++;
        if (g !== e) begin failures++; $display("FAIL after_flush_capture got=%h exp=%h", g, e); end
        stall_i = 1'b1; rst_i = 1'b1;
        sb_q.push_back('0);
        tick();
        e = sb_q.pop_front(); g = sample();
        checks++;
        if (g !== e) begin failures++; $display("FAIL reset_mid_stall got=%h exp=%h", g, e); end
        stall_i = 1'b0; rst_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        test_reset();
        test_add();
        test_forward();
        test_load_use();
        test_back_to_back();
        test_stall_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
ID/EX pipeline stage sitting directly upstream of the ALU. It registers the decoded instruction fields and applies forwarding from EX/MEM and MEM/WB. It selects register, immediate or shift-amount operands and drives the ALU's src1/src2/ctrl inputs. It also detects load-use hazards and inserts bubbles, supporting hold (stall) and flush from pipeline control.

Parameters:
DATA_W, 32, operand/result width
REG_AW, 5, register address width
CTRL_W, 4, ALU control width (codes: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 8 SRA, 9 LUI, 12 NOR)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous, active-high reset
id_valid_i  in  1  ID slot holds a real instruction
id_rs_addr_i / id_rt_addr_i  in  5  source register numbers
id_rs_data_i / id_rt_data_i  in  32  register-file read data
id_imm_i  in  16  instruction immediate
id_shamt_i  in  5  shift amount field
id_alu_ctrl_i  in  4  ALU operation
id_alu_src_i  in  1  1: src2 = extended immediate
id_shift_src_i  in  1  1: src1 = zero-extended shamt
id_sign_ext_i  in  1  1: sign-extend imm, 0: zero-extend
id_rd_addr_i  in  5  destination register
id_reg_write_i / id_mem_read_i  in  1  writeback enable / load
stall_i  in  1  hold stage contents
flush_i  in  1  replace incoming instruction with bubble
exmem_reg_write_i  in  1; exmem_rd_i  in  5; exmem_result_i  in  32  EX/MEM forward source
memwb_reg_write_i  in  1; memwb_rd_i  in  5; memwb_data_i  in  32  MEM/WB forward source
src1_o / src2_o  out  32  ALU operands
alu_ctrl_o  out  4  ALU control
ex_rt_data_o  out  32  forwarded rt value (store data)
ex_valid_o, ex_reg_write_o, ex_mem_read_o  out  1  EX-stage qualifiers
ex_rd_o  out  5  EX-stage destination
load_use_stall_o  out  1  combinational; request upstream PC/IF/ID hold

Behaviour:
- Reset: all registered fields are 0; ex_valid_o=0; all outputs are 0.
- Per-edge update priority: rst_i > stall_i (hold all) > flush_i (bubble) > load_use_stall_o (bubble) > capture ID fields, with ex_valid_o=id_valid_i.
- Bubble: ex_valid=0, reg_write=0, mem_read=0, rd=0, alu_ctrl=0.
- Load-use: load_use_stall_o = ex_valid & ex_mem_read & ex_rd!=0 & id_valid_i & (id_rs_addr_i==ex_rd | id_rt_addr_i==ex_rd).
  - It is masked by stall_i.
  - It is not masked by flush_i, but flush still produces a bubble.
- Forwarding is combinational from registered rs/rt and the current exmem/memwb inputs, for each of rs and rt:
  - If exmem_reg_write_i & exmem_rd_i!=0 & exmem_rd_i==addr, use exmem_result_i.
  - Otherwise, if the same condition holds for MEM/WB, use memwb_data_i.
  - Otherwise, use the registered data.
  - EX/MEM wins over MEM/WB.
  - Register 0 is never forwarded.
- Operand selection:
  - src1_o = shift_src ? {27'b0,shamt} : fwd_rs.
  - src2_o = alu_src ? ext(imm) : fwd_rt.
  - ext is sign- or zero-extension to 32 bits per id_sign_ext_i.
  - ex_rt_data_o = fwd_rt regardless of alu_src.
- While ex_valid_o=0, src1_o, src2_o and ex_rt_data_o are forced to 0.
- During stall_i, registered fields are held; forwarding continues to re-evaluate against live exmem/memwb inputs.
- Latency: ID inputs appear on outputs 1 cycle later; there are no multi-cycle states.
- Reset asserted mid-stall or mid-hazard clears everything on that edge.

Decomposition:
- Shared package (pipeline_pkg): ALU ctrl code constants, REG_AW/DATA_W, and the ID/EX field bundle struct.
- One natural sub-module: fwd_select, the per-operand forwarding priority mux, instantiated twice (rs, rt).
- Hazard detection stays inline.

Test Plan:
- Reset: rst_i=1 for 2 cycles with arbitrary ID inputs -> all outputs 0, ex_valid_o=0.
- ADD, no hazards: rs_data=5, rt_data=7, ctrl=2, rd=3 -> next cycle src1_o=5, src2_o=7, alu_ctrl_o=2, ex_rd_o=3, ex_valid_o=1.
- Forward priority: EX holds rs=1 (data 0); exmem rd=1 result 0x10 and memwb rd=1 data 0x20 -> src1_o=0x10. Drop exmem_reg_write_i -> src1_o=0x20. Set exmem_rd_i=0 with result 0xFFFF and rs=0 -> src1_o=0.
- Load-use: EX holds lw rd=4; ID rs=4 valid -> load_use_stall_o=1 the same cycle, next edge ex_valid_o=0 and ex_reg_write_o=0. Repeat with stall_i=1 -> load_use_stall_o=0 and contents held.
- Immediate/shift: imm=0xFFFC, alu_src=1, sign_ext=1 -> src2_o=0xFFFFFFFC; sign_ext=0 -> src2_o=0x0000FFFC; shift_src=1, shamt=3, ctrl=8 -> src1_o=3.
- Stall vs flush: stall_i=1 with flush_i=1 -> all fields held. Then flush_i alone -> bubble, ex_valid_o=0, all operand outputs 0.
